// File: rtl/demod_acq_ctrl.sv
// Acquisition sequencer: shadow config with atomic commit, trigger qualification, holdoff and IQ gating.
// Defining ACQ_TIMEOUT_EN adds an ACQUIRE-stall watchdog that drives timeout_err.
module demod_acq_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [13:0]      cfg_addr,
    input  logic             cfg_wr_en,
    input  logic [32:0]      cfg_wr_data,
    input  logic             trigger,
    input  logic             iq_valid,
    output logic             acq_en,
    output logic [1:0]       analyze_mode,
    output logic [CNT_W-1:0] num_data_pts,
    output logic [CNT_W-1:0] pts_count,
    output logic [2:0]       acq_state,
    output logic             acq_done,
    output logic [7:0]       trig_miss_cnt,
    output logic             cfg_err,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        HOLDOFF = 3'd2,
        ACQUIRE = 3'd3,
        DONE    = 3'd4
    } acqState_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    acqState_t        stateR;
    acqState_t        nextStateS;
    logic [CNT_W-1:0] shNumPtsR;
    logic [CNT_W-1:0] shHoldoffR;
    logic [1:0]       shModeR;
    logic             contR;
    logic [CNT_W-1:0] numPtsR;
    logic [CNT_W-1:0] holdoffR;
    logic [1:0]       modeR;
    logic [CNT_W-1:0] holdCntR;
    logic [CNT_W-1:0] ptsCountR;
    logic [7:0]       missCntR;
    logic             trigMetaR;
    logic             trigSyncR;
    logic             trigPrevR;
    logic             cfgErrR;
    logic             acqEnR;
    logic             acqDoneR;

    logic ctrlWrS;
    logic armS;
    logic abortS;
    logic trigEdgeS;
    logic commitS;
    logic setCfgErrS;
    logic countS;
    logic timeoutS;

    assign ctrlWrS   = cfg_wr_en && (cfg_addr == 14'd0);
    assign armS      = ctrlWrS && cfg_wr_data[0];
    assign abortS    = ctrlWrS && cfg_wr_data[1];
    assign trigEdgeS = trigSyncR && !trigPrevR;
    // An aborting cycle never counts, so pts_count holds across ABORT
    assign countS    = (stateR == ACQUIRE) && iq_valid && !abortS;

    // Next-state decode with commit and config-error strobes
    always_comb begin
        nextStateS = stateR;
        commitS    = 1'b0;
        setCfgErrS = 1'b0;
        if (abortS) begin
            nextStateS = IDLE;
        end else begin
            case (stateR)
                IDLE: begin
                    if (armS && (shNumPtsR != CNT_ZERO)) begin
                        nextStateS = ARMED;
                        commitS    = 1'b1;
                    end else if (armS) begin
                        setCfgErrS = 1'b1;
                    end else begin
                        nextStateS = IDLE;
                    end
                end
                ARMED: begin
                    if (trigEdgeS && (holdoffR == CNT_ZERO)) begin
                        nextStateS = ACQUIRE;
                    end else if (trigEdgeS) begin
                        nextStateS = HOLDOFF;
                    end else begin
                        nextStateS = ARMED;
                    end
                end
                HOLDOFF: begin
                    if (holdCntR == (holdoffR - CNT_ONE)) begin
                        nextStateS = ACQUIRE;
                    end else begin
                        nextStateS = HOLDOFF;
                    end
                end
                ACQUIRE: begin
                    if (iq_valid && (ptsCountR == (numPtsR - CNT_ONE))) begin
                        nextStateS = DONE;
                    end else if (timeoutS) begin
                        nextStateS = IDLE;
                    end else begin
                        nextStateS = ACQUIRE;
                    end
                end
                DONE: begin
                    if (contR) begin
                        nextStateS = ARMED;
                        commitS    = 1'b1;
                    end else begin
                        nextStateS = IDLE;
                    end
                end
                default: begin
                    nextStateS = IDLE;
                end
            endcase
        end
    end

    // State register and registered state decodes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateR   <= IDLE;
            acqEnR   <= 1'b0;
            acqDoneR <= 1'b0;
        end else begin
            stateR   <= nextStateS;
            acqEnR   <= (nextStateS == ACQUIRE);
            acqDoneR <= (nextStateS == DONE);
        end
    end

    // Two-flop trigger synchronizer plus previous sample for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trigMetaR <= 1'b0;
            trigSyncR <= 1'b0;
            trigPrevR <= 1'b0;
        end else begin
            trigMetaR <= trigger;
            trigSyncR <= trigMetaR;
            trigPrevR <= trigSyncR;
        end
    end

    // Shadow configuration registers, writable in any state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shNumPtsR  <= CNT_ZERO;
            shHoldoffR <= CNT_ZERO;
            shModeR    <= 2'b00;
            contR      <= 1'b0;
        end else if (cfg_wr_en) begin
            case (cfg_addr)
                14'd0:   contR      <= cfg_wr_data[2];
                14'd1:   shNumPtsR  <= cfg_wr_data[CNT_W-1:0];
                14'd2:   shModeR    <= cfg_wr_data[1:0];
                14'd3:   shHoldoffR <= cfg_wr_data[CNT_W-1:0];
                default: contR      <= contR;
            endcase
        end else begin
            contR <= contR;
        end
    end

    // Committed config, sample count and missed-trigger count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            numPtsR   <= CNT_ZERO;
            holdoffR  <= CNT_ZERO;
            modeR     <= 2'b00;
            ptsCountR <= CNT_ZERO;
            missCntR  <= 8'd0;
        end else if (commitS) begin
            numPtsR   <= shNumPtsR;
            holdoffR  <= shHoldoffR;
            modeR     <= shModeR;
            ptsCountR <= CNT_ZERO;
            missCntR  <= 8'd0;
        end else begin
            if (countS) begin
                ptsCountR <= ptsCountR + CNT_ONE;
            end else begin
                ptsCountR <= ptsCountR;
            end
            if (trigEdgeS && (stateR != ARMED) && (missCntR != 8'hFF)) begin
                missCntR <= missCntR + 8'd1;
            end else begin
                missCntR <= missCntR;
            end
        end
    end

    // Cycles spent in HOLDOFF; cleared everywhere else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holdCntR <= CNT_ZERO;
        end else if (stateR == HOLDOFF) begin
            holdCntR <= holdCntR + CNT_ONE;
        end else begin
            holdCntR <= CNT_ZERO;
        end
    end

    // Sticky config error; setting wins over the clear from the same CTRL write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfgErrR <= 1'b0;
        end else if (setCfgErrS) begin
            cfgErrR <= 1'b1;
        end else if (ctrlWrS) begin
            cfgErrR <= 1'b0;
        end else begin
            cfgErrR <= cfgErrR;
        end
    end

`ifdef ACQ_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};

    logic [WD_W-1:0] wdCntR;
    logic            timeoutErrR;

    assign timeoutS = (stateR == ACQUIRE) && !iq_valid && !abortS && (wdCntR == WD_LAST);

    // Watchdog: consecutive ACQUIRE cycles without a sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdCntR <= {WD_W{1'b0}};
        end else if ((stateR == ACQUIRE) && (nextStateS == ACQUIRE) && !iq_valid) begin
            wdCntR <= wdCntR + WD_ONE;
        end else begin
            wdCntR <= {WD_W{1'b0}};
        end
    end

    // Sticky timeout error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeoutErrR <= 1'b0;
        end else if (timeoutS) begin
            timeoutErrR <= 1'b1;
        end else if (ctrlWrS) begin
            timeoutErrR <= 1'b0;
        end else begin
            timeoutErrR <= timeoutErrR;
        end
    end

    assign timeout_err = timeoutErrR;
`else
    logic unusedParam;
    assign unusedParam = (TIMEOUT_CYC != 0);
    assign timeoutS    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    logic unusedBits;
    assign unusedBits = ^cfg_wr_data[32:CNT_W];

    assign acq_state     = stateR;
    assign acq_en        = acqEnR;
    assign acq_done      = acqDoneR;
    assign analyze_mode  = modeR;
    assign num_data_pts  = numPtsR;
    assign pts_count     = ptsCountR;
    assign trig_miss_cnt = missCntR;
    assign cfg_err       = cfgErrR;

endmodule

// File: doc/demod_acq_ctrl.md
# demod_acq_ctrl

Acquisition sequencer for the demodulation datapath. Decodes PC-port configuration writes into shadow registers and commits them atomically on arm. Qualifies the hardware trigger, applies a holdoff, then gates the IQ stream for exactly `num_data_pts` valid samples. Sits between the PC/HVI memory ports and the demod/analyze chain, and drives their enable, mode and point-count inputs.

## Interface
Parameters:
- `CNT_W`, 16, width of point count and holdoff counters
- `TIMEOUT_CYC`, 65535, watchdog limit in clk cycles (used only with `ACQ_TIMEOUT_EN`)

Ports:
- `clk`  in  1  system clock (100 MHz)
- `rst`  in  1  asynchronous, active-low reset
- `cfg_addr`  in  14  PC-port write address
- `cfg_wr_en`  in  1  PC-port write strobe, one word per cycle
- `cfg_wr_data`  in  33  PC-port write data; bit 32 ignored
- `trigger`  in  1  raw external trigger (trigger_in[0]), asynchronous
- `iq_valid`  in  1  demod IQ sample-valid strobe
- `acq_en`  out  1  high while samples are being accepted
- `analyze_mode`  out  2  committed analysis mode
- `num_data_pts`  out  CNT_W  committed point count
- `pts_count`  out  CNT_W  samples accepted in the current or last run
- `acq_state`  out  3  FSM state encoding
- `acq_done`  out  1  one-cycle pulse at normal completion
- `trig_miss_cnt`  out  8  saturating count of triggers seen outside ARMED
- `cfg_err`  out  1  sticky flag: arm attempted with NUM_PTS = 0
- `timeout_err`  out  1  sticky flag: watchdog expired

## Operation
- Register map. A write occurs when `cfg_wr_en`=1 and the address matches; other addresses are ignored.
  - 0 CTRL: bit0 ARM, bit1 ABORT, bit2 CONT. ARM and ABORT are self-clearing strobes. CONT is stored.
  - 1 NUM_PTS[CNT_W-1:0]
  - 2 MODE[1:0]
  - 3 HOLDOFF[CNT_W-1:0]
  - A CTRL write also clears `cfg_err` and `timeout_err`.
- Shadow registers (NUM_PTS, MODE, HOLDOFF) can be written in any state. They take effect only at commit.
- FSM states: IDLE=0, ARMED=1, HOLDOFF=2, ACQUIRE=3, DONE=4.
  - IDLE → ARMED on ARM with shadow NUM_PTS≠0. This is a commit: shadows are copied to the outputs and internal holdoff, `pts_count` and `trig_miss_cnt` are cleared.
  - ARM with shadow NUM_PTS=0 stays in IDLE and sets `cfg_err`.
  - ARMED → HOLDOFF on a trigger rising edge, or ARMED → ACQUIRE if HOLDOFF=0.
  - HOLDOFF → ACQUIRE after exactly HOLDOFF cycles spent in HOLDOFF.
  - ACQUIRE: `acq_en`=1. Each `iq_valid` increments `pts_count`. When `iq_valid` arrives with `pts_count`=num_data_pts−1, move to DONE.
  - DONE: `acq_done`=1 for that cycle. Next state is ARMED with a re-commit if CONT=1, otherwise IDLE.
- ABORT in any state → IDLE on the next edge. `acq_en` falls, no `acq_done` is produced, and `pts_count` holds.
  - ARM and ABORT in the same write: ABORT wins.
  - ARM outside IDLE is ignored.
- A trigger edge in any state other than ARMED increments `trig_miss_cnt`, saturating at 255.
- `iq_valid` is counted only while the state is ACQUIRE. A strobe in the cycle the FSM enters ACQUIRE is not counted.

## Timing
- Reset: all outputs 0, state IDLE, shadows 0, CONT=0.
- Config writes are registered. A CTRL write at edge E changes state at edge E, so `acq_state` shows ARMED after E.
- `trigger` passes through a 2-flop synchronizer followed by edge detection. If `trigger` is first sampled high at edge E0, ARMED exits at edge E2.
- `acq_en` is a registered decode of state and rises on the edge that enters ACQUIRE.
- The final counted `iq_valid` at edge E gives DONE with `acq_en`=0 and `acq_done`=1 in the cycle after E.
- A counter at 2^CNT_W−1 never wraps, because NUM_PTS bounds it.
- Reset assertion mid-run takes effect immediately (asynchronous). Release is synchronous to `clk`.

## Configuration
- `ACQ_TIMEOUT_EN` defined:
  - A watchdog counts consecutive ACQUIRE cycles without `iq_valid`.
  - On reaching TIMEOUT_CYC, the FSM goes → IDLE, sets `timeout_err`, drops `acq_en`, and produces no `acq_done`.
  - The watchdog clears on every `iq_valid` and on leaving ACQUIRE.
- `ACQ_TIMEOUT_EN` undefined: no watchdog logic, and `timeout_err` is tied to 0.

## Test plan
- Write NUM_PTS=4, HOLDOFF=0, then ARM, then pulse `trigger` → `acq_en` high and exactly 4 `iq_valid` counted; `acq_done` pulses once; state returns to IDLE; `pts_count`=4.
- HOLDOFF=10, trigger at E0 → ACQUIRE entered at E2+10; `iq_valid` strobes during HOLDOFF are not counted.
- CONT=1, NUM_PTS=2, three triggers → two completed runs with re-arm between them; trigger during ACQUIRE gives `trig_miss_cnt`=1.
- Shadow NUM_PTS=0 then ARM → stays IDLE with `cfg_err`=1. Writing NUM_PTS=8 during ACQUIRE does not change `num_data_pts` until the next commit.
- ABORT after 3 of 5 samples → IDLE next cycle, `pts_count`=3, no `acq_done`. ARM+ABORT in one write stays IDLE.
- With `ACQ_TIMEOUT_EN` and TIMEOUT_CYC=16, stop `iq_valid` in ACQUIRE → IDLE after 16 cycles with `timeout_err`=1.
